// File: rtl/furv_pkg.sv
// Shared RV32I decode constants, ALU operation codes and core FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package furv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Word-only memory access funct3, JALR funct3
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_t;

  typedef enum logic {EXEC, LOAD_WB} state_t;

endpackage

// File: rtl/furv_alu.sv
// Combinational integer ALU plus equality/signed/unsigned compare flags for branches.
// Latency: 0 cycles (pure combinational). MUL present only when FURV_MUL_EN is defined.
// Backpressure: none.
module furv_alu
  import furv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     alu_op_i,
  output logic [31:0] result_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

  // Result mux; shift amounts use only the low five bits of b.
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SLT:  result_o = {31'b0, lt_o};
      ALU_SLTU: result_o = {31'b0, ltu_o};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = 32'($signed(a_i) >>> b_i[4:0]);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
`ifdef FURV_MUL_EN
      ALU_MUL:  result_o = a_i * b_i;
`endif
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/furv_core.sv
// Minimal RV32I core: decode, immediates, register file and EXEC/LOAD_WB FSM.
// Latency: 1 cycle per instruction, 2 for LW (registered bus read). Optional MUL via FURV_MUL_EN.
// Backpressure: none; the bus must accept a store the cycle it is strobed.
module furv_core
  import furv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] addr,
  output logic        mem_read,
  output logic        mem_en
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [31:0] rf_q [0:31];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  alu_op_t     alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_ok, alu_eq, alu_lt, alu_ltu, br_take;

  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_val;
  logic        mem_en_c, mem_read_c;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign f7     = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  assign pc       = pc_q;
  assign data_out = rs2_val;
  assign addr     = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign mem_read = mem_read_c;
  // The strobe is forced low while reset is held so no bus access leaks out.
  assign mem_en   = mem_en_c & rst_n;

  furv_alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .alu_op_i (alu_op),
    .result_o (alu_res),
    .eq_o     (alu_eq),
    .lt_o     (alu_lt),
    .ltu_o    (alu_ltu)
  );

  // ALU operand/operation select; alu_ok is low for encodings treated as NOP.
  always_comb begin
    alu_a  = rs1_val;
    alu_b  = rs2_val;
    alu_op = ALU_ADD;
    alu_ok = 1'b0;
    if (opcode == OP_IMM) begin
      alu_b  = imm_i;
      alu_ok = 1'b1;
      case (f3)
        F3_ADD:  alu_op = ALU_ADD;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        F3_SLL: begin
          alu_op = ALU_SLL;
          alu_ok = (f7 == F7_BASE);
        end
        default: begin
          alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          alu_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
      endcase
    end else if (opcode == OP_OP) begin
      alu_ok = 1'b1;
      case ({f7, f3})
        {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
        {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
        {F7_BASE, F3_SLL}:  alu_op = ALU_SLL;
        {F7_BASE, F3_SLT}:  alu_op = ALU_SLT;
        {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
        {F7_BASE, F3_XOR}:  alu_op = ALU_XOR;
        {F7_BASE, F3_SR}:   alu_op = ALU_SRL;
        {F7_ALT,  F3_SR}:   alu_op = ALU_SRA;
        {F7_BASE, F3_OR}:   alu_op = ALU_OR;
        {F7_BASE, F3_AND}:  alu_op = ALU_AND;
`ifdef FURV_MUL_EN
        {F7_MULDIV, F3_ADD}: alu_op = ALU_MUL;
`endif
        default: alu_ok = 1'b0;
      endcase
    end
  end

  // Branch condition from the rs1/rs2 compare flags; reserved funct3 never branches.
  always_comb begin
    br_take = 1'b0;
    case (f3)
      F3_BEQ:  br_take = alu_eq;
      F3_BNE:  br_take = ~alu_eq;
      F3_BLT:  br_take = alu_lt;
      F3_BGE:  br_take = ~alu_lt;
      F3_BLTU: br_take = alu_ltu;
      F3_BGEU: br_take = ~alu_ltu;
      default: br_take = 1'b0;
    endcase
  end

  // Next-state, next-pc, register write and bus strobe for the EXEC/LOAD_WB FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_plus4;
    ld_rd_d    = ld_rd_q;
    wr_en      = 1'b0;
    wr_rd      = rd;
    wr_val     = alu_res;
    mem_en_c   = 1'b0;
    mem_read_c = 1'b0;
    if (state_q == LOAD_WB) begin
      wr_en   = 1'b1;
      wr_rd   = ld_rd_q;
      wr_val  = data_in;
      state_d = EXEC;
    end else begin
      case (opcode)
        OP_LUI: begin
          wr_en  = 1'b1;
          wr_val = imm_u;
        end
        OP_AUIPC: begin
          wr_en  = 1'b1;
          wr_val = pc_q + imm_u;
        end
        OP_JAL: begin
          wr_en  = 1'b1;
          wr_val = pc_plus4;
          pc_d   = (pc_q + imm_j) & 32'hFFFF_FFFC;
        end
        OP_JALR: begin
          if (f3 == F3_JALR) begin
            wr_en  = 1'b1;
            wr_val = pc_plus4;
            pc_d   = (rs1_val + imm_i) & 32'hFFFF_FFFC;
          end
        end
        OP_BRANCH: begin
          if (br_take) pc_d = (pc_q + imm_b) & 32'hFFFF_FFFC;
        end
        OP_LOAD: begin
          if (f3 == F3_LW) begin
            mem_en_c   = 1'b1;
            mem_read_c = 1'b1;
            pc_d       = pc_q;
            ld_rd_d    = rd;
            state_d    = LOAD_WB;
          end
        end
        OP_STORE: begin
          if (f3 == F3_SW) mem_en_c = 1'b1;
        end
        OP_IMM, OP_OP: begin
          wr_en = alu_ok;
        end
        default: ;
      endcase
    end
  end

  // Architectural state; reset also aborts an in-flight load write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EXEC;
      pc_q    <= RESET_PC;
      ld_rd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ld_rd_q <= ld_rd_d;
    end
  end

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wr_en && (wr_rd != 5'd0)) begin
      rf_q[wr_rd] <= wr_val;
    end
  end

endmodule

// File: tb/tb_furv_core.sv
// Directed self-checking bench for furv_core with a registered-read word RAM model.
// Registers are observed by presenting SW xN,0(x0) and reading data_out without clocking.
module tb_furv_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_en;

  logic [31:0] ram [0:255];
  int checks = 0;
  int failures = 0;

  furv_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .pc          (pc),
    .data_in     (data_in),
    .data_out    (data_out),
    .addr        (addr),
    .mem_read    (mem_read),
    .mem_en      (mem_en)
  );

  always #5 clk = ~clk;

  // Registered-read RAM: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_read) data_in <= ram[addr[9:2]];
      else          ram[addr[9:2]] <= data_out;
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction across a rising edge, then check the resulting pc.
  task automatic step(input logic [31:0] ins, input logic [31:0] exp_pc, input string tag);
    instruction = ins;
    @(posedge clk);
    #1;
    chk(tag, pc, exp_pc);
  endtask

  // Peek register idx through the store-data path (no clock edge).
  task automatic peek(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    instruction = enc_s(12'd0, idx, 5'd0);
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    data_in     = 32'd0;
    rst_n       = 1'b0;
    instruction = enc_s(12'd0, 5'd0, 5'd0);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. ADDI
    instruction = addi(5'd1, 5'd0, 12'd5);
    #1;
    chk("addi_mem_en", {31'b0, mem_en}, 32'h0);
    step(addi(5'd1, 5'd0, 12'd5), 32'h4, "addi_pc");
    peek(5'd1, 32'd5, "addi_x1");

    // 2. SW x1,4(x2)
    step(addi(5'd2, 5'd0, 12'h100), 32'h8, "addi_x2_pc");
    instruction = enc_s(12'd4, 5'd1, 5'd2);
    #1;
    chk("sw_mem_en", {31'b0, mem_en}, 32'h1);
    chk("sw_mem_read", {31'b0, mem_read}, 32'h0);
    chk("sw_addr", addr, 32'h104);
    chk("sw_data", data_out, 32'd5);
    step(enc_s(12'd4, 5'd1, 5'd2), 32'hC, "sw_pc");

    // 3. LW x3,4(x2): two cycles
    instruction = enc_i(12'd4, 5'd2, 3'b010, 5'd3, 7'b0000011);
    #1;
    chk("lw_mem_en", {31'b0, mem_en}, 32'h1);
    chk("lw_mem_read", {31'b0, mem_read}, 32'h1);
    chk("lw_addr", addr, 32'h104);
    step(instruction, 32'hC, "lw_pc_held");
    chk("lw_wb_mem_en", {31'b0, mem_en}, 32'h0);
    step(instruction, 32'h10, "lw_wb_pc");
    peek(5'd3, 32'd5, "lw_x3");

    // 4. Branches
    step(enc_b(13'd8, 5'd1, 5'd1, 3'b000), 32'h18, "beq_taken");
    step(enc_b(13'd8, 5'd1, 5'd1, 3'b001), 32'h1C, "bne_not_taken");
    step(addi(5'd4, 5'd0, 12'hFFF), 32'h20, "addi_x4_pc");
    step(addi(5'd5, 5'd0, 12'd1), 32'h24, "addi_x5_pc");
    step(enc_b(13'd8, 5'd4, 5'd5, 3'b100), 32'h2C, "blt_taken");
    step(enc_b(13'd8, 5'd4, 5'd5, 3'b110), 32'h30, "bltu_not_taken");
    step(enc_b(13'd8, 5'd4, 5'd5, 3'b101), 32'h34, "bge_not_taken");
    step(enc_b(13'd8, 5'd4, 5'd5, 3'b111), 32'h3C, "bgeu_taken");
    step(addi(5'd0, 5'd0, 12'd7), 32'h40, "addi_x0_pc");
    peek(5'd0, 32'd0, "x0_zero");

    // 5. JAL / JALR
    step(enc_j(21'h20, 5'd1), 32'h60, "jal_pc");
    peek(5'd1, 32'h44, "jal_link");
    step(enc_i(12'd3, 5'd1, 3'b000, 5'd0, 7'b1100111), 32'h44, "jalr_pc");
    step(enc_i(12'd8, 5'd1, 3'b000, 5'd1, 7'b1100111), 32'h4C, "jalr_rd_eq_rs1_pc");
    peek(5'd1, 32'h48, "jalr_link");

    // ALU and optional MUL
    step(addi(5'd6, 5'd0, 12'd3), 32'h50, "addi_x6_pc");
    step(addi(5'd7, 5'd0, 12'hFFE), 32'h54, "addi_x7_pc");
    step(addi(5'd8, 5'd0, 12'h055), 32'h58, "addi_x8_pc");
    step(enc_r(7'b0000001, 5'd7, 5'd6, 3'b000, 5'd8), 32'h5C, "mul_pc");
`ifdef FURV_MUL_EN
    peek(5'd8, 32'hFFFF_FFFA, "mul_result");
`else
    peek(5'd8, 32'h55, "mul_nop");
`endif
    step(enc_r(7'b0100000, 5'd7, 5'd6, 3'b000, 5'd9), 32'h60, "sub_pc");
    peek(5'd9, 32'd5, "sub_x9");
    step(enc_i(12'h401, 5'd7, 3'b101, 5'd10, 7'b0010011), 32'h64, "srai_pc");
    peek(5'd10, 32'hFFFF_FFFF, "srai_x10");
    step(enc_i(12'd28, 5'd7, 3'b101, 5'd11, 7'b0010011), 32'h68, "srli_pc");
    peek(5'd11, 32'hF, "srli_x11");
    step(enc_r(7'b0, 5'd4, 5'd5, 3'b011, 5'd12), 32'h6C, "sltu_pc");
    peek(5'd12, 32'd1, "sltu_x12");
    step(enc_r(7'b0, 5'd4, 5'd5, 3'b010, 5'd13), 32'h70, "slt_pc");
    peek(5'd13, 32'd0, "slt_x13");
    step({20'h12345, 5'd14, 7'b0110111}, 32'h74, "lui_pc");
    peek(5'd14, 32'h1234_5000, "lui_x14");
    step({20'h00001, 5'd15, 7'b0010111}, 32'h78, "auipc_pc");
    peek(5'd15, 32'h0000_1074, "auipc_x15");
    instruction = 32'h0000_0073;
    #1;
    chk("ecall_mem_en", {31'b0, mem_en}, 32'h0);
    step(32'h0000_0073, 32'h7C, "ecall_pc");
    step(enc_r(7'b0000001, 5'd7, 5'd6, 3'b001, 5'd8), 32'h80, "mulh_nop_pc");
`ifdef FURV_MUL_EN
    peek(5'd8, 32'hFFFF_FFFA, "mulh_nop_x8");
`else
    peek(5'd8, 32'h55, "mulh_nop_x8");
`endif

    // 6. Reset asserted during LOAD_WB aborts the load
    step(addi(5'd13, 5'd0, 12'h077), 32'h84, "addi_x13_pc");
    step(enc_i(12'd4, 5'd2, 3'b010, 5'd13, 7'b0000011), 32'h84, "lw2_pc_held");
    rst_n = 1'b0;
    #1;
    chk("abort_pc", pc, 32'h0);
    chk("abort_mem_en", {31'b0, mem_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    peek(5'd13, 32'd0, "abort_x13");
    step(addi(5'd1, 5'd0, 12'd1), 32'h4, "post_reset_pc");
    peek(5'd1, 32'd1, "post_reset_x1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
